fetch_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the synchronous-read instruction memory.
- Buffers returned {PC, instruction} pairs in a small FIFO, so decode stalls (Reg_Stall) do not throttle memory.
- Branch/jump redirects from the execute-stage BranchUnit (PcSel/BrPC) flush the queue and any in-flight fetch.

---
 rtl/fetch_prefetch_queue_if.sv | 30 +++
 rtl/fetch_prefetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: redirect request, instruction-memory port and the
// {pc, instr} stream presented to decode.
interface fetch_prefetch_queue_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic [CNT_W-1:0] count;

  // master: the prefetch queue itself; slave: execute/decode/memory side
  modport master (
    input  redirect, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues reads to a
// synchronous-read imem and buffers {pc, instr} pairs ahead of decode.
module fetch_prefetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] PC_STEP      = PC_W'(32'd4);
  localparam logic [CNT_W:0]  CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]  fetch_pc_r;
  logic [PC_W-1:0]  pending_pc_r;
  logic             pending_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PC_W-1:0]  pc_mem_r    [DEPTH];
  logic [INS_W-1:0] instr_mem_r [DEPTH];

  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             out_valid_s;
  logic [CNT_W:0]   credit_s;
  logic [PC_W-1:0]  out_pc_s;
  logic [INS_W-1:0] out_instr_s;

  // Handshake qualifiers; an in-flight read holds a slot, so a same-cycle pop is not credited
  always_comb begin
    credit_s    = {1'b0, count_r} + {{CNT_W{1'b0}}, pending_r};
    issue_s     = 1'b0;
    push_s      = 1'b0;
    out_valid_s = 1'b0;
    pop_s       = 1'b0;
    if (bus.redirect) begin
      issue_s     = 1'b0;
      push_s      = 1'b0;
      out_valid_s = 1'b0;
      pop_s       = 1'b0;
    end else begin
      issue_s     = (credit_s < CREDIT_LIMIT);
      push_s      = pending_r;
      out_valid_s = (count_r != {CNT_W{1'b0}});
      pop_s       = out_valid_s && bus.out_ready;
    end
  end

  // Fetch PC, in-flight tracking, pointers and occupancy; redirect outranks all traffic
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r   <= {PC_W{1'b0}};
      pending_r    <= 1'b0;
      pending_pc_r <= {PC_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
    end else if (bus.redirect) begin
      fetch_pc_r <= bus.redirect_pc;
      pending_r  <= 1'b0;
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        pending_r    <= 1'b1;
        pending_pc_r <= fetch_pc_r;
        fetch_pc_r   <= fetch_pc_r + PC_STEP;
      end else begin
        pending_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; returning read data lands at the tail alongside its PC
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      pc_mem_r[wr_ptr_r]    <= pending_pc_r;
      instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
    end
  end

  // Head view, forced to zero when empty
  always_comb begin
    out_pc_s    = {PC_W{1'b0}};
    out_instr_s = {INS_W{1'b0}};
    if (count_r != {CNT_W{1'b0}}) begin
      out_pc_s    = pc_mem_r[rd_ptr_r];
      out_instr_s = instr_mem_r[rd_ptr_r];
    end else begin
      out_pc_s    = {PC_W{1'b0}};
      out_instr_s = {INS_W{1'b0}};
    end
  end

  assign bus.imem_addr = fetch_pc_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = out_pc_s;
  assign bus.out_instr = out_instr_s;
  assign bus.count     = count_r;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a one-cycle-latency imem model
// returning {addr, 23'h0}.
module tb_fetch_prefetch_queue;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_prefetch_queue_if #(.PC_W(9), .INS_W(32), .DEPTH(4)) bus ();

  fetch_prefetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous-read instruction memory
  always @(posedge clk) bus.imem_rdata <= {bus.imem_addr, 23'h0};

  function automatic logic [31:0] instr_of(input logic [8:0] pc);
    return {pc, 23'h0};
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 9'h000;
    bus.out_ready   = 1'b0;

    // 1: reset state, then streaming with out_ready=1
    tick(2);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("t1_lat_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_first_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_first_pc", 64'(bus.out_pc), 64'd0);
    chk("t1_first_count", 64'(bus.count), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_pc", 64'(bus.out_pc), 64'(4 * k));
      chk("t1_instr", 64'(bus.out_instr), 64'(instr_of(9'(4 * k))));
      chk("t1_count", 64'(bus.count), 64'd1);
    end

    // 2: decode stalled for 10 cycles, then drain
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    tick(10);
    chk("t2_count_full", 64'(bus.count), 64'd4);
    chk("t2_fetch_stop", 64'(bus.imem_addr), 64'd16);
    chk("t2_head_pc", 64'(bus.out_pc), 64'd0);
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_count_pop", 64'(bus.count), 64'd3);
    chk("t2_pc", 64'(bus.out_pc), 64'd4);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("t2_valid_run", 64'(bus.out_valid), 64'd1);
      chk("t2_pc_run", 64'(bus.out_pc), 64'(4 * k));
    end

    // 3: redirect with count=2 and a read in flight
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    tick(3);
    chk("t3_count_pre", 64'(bus.count), 64'd2);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h040;
    #1;
    chk("t3_valid_masked", 64'(bus.out_valid), 64'd0);
    tick();
    bus.redirect = 1'b0;
    chk("t3_count_flush", 64'(bus.count), 64'd0);
    chk("t3_valid_flush", 64'(bus.out_valid), 64'd0);
    chk("t3_addr", 64'(bus.imem_addr), 64'h040);
    tick();
    chk("t3_lat_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_pc0", 64'(bus.out_pc), 64'h040);
    chk("t3_instr0", 64'(bus.out_instr), 64'(instr_of(9'h040)));
    bus.out_ready = 1'b1;
    tick();
    chk("t3_pc1", 64'(bus.out_pc), 64'h044);

    // 4: redirect coincident with a pop request at count=3
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    tick(4);
    chk("t4_count_pre", 64'(bus.count), 64'd3);
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h100;
    #1;
    chk("t4_valid_masked", 64'(bus.out_valid), 64'd0);
    tick();
    bus.redirect = 1'b0;
    chk("t4_count", 64'(bus.count), 64'd0);
    chk("t4_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_addr", 64'(bus.imem_addr), 64'h100);
    tick(2);
    chk("t4_pc", 64'(bus.out_pc), 64'h100);

    // 5: PC wrap at the top of the 9-bit space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h1FC;
    tick();
    bus.redirect = 1'b0;
    tick(2);
    chk("t5_pc_1fc", 64'(bus.out_pc), 64'h1FC);
    chk("t5_instr_1fc", 64'(bus.out_instr), 64'(instr_of(9'h1FC)));
    tick();
    chk("t5_pc_000", 64'(bus.out_pc), 64'h000);
    chk("t5_valid_000", 64'(bus.out_valid), 64'd1);
    tick();
    chk("t5_pc_004", 64'(bus.out_pc), 64'h004);
    chk("t5_instr_004", 64'(bus.out_instr), 64'(instr_of(9'h004)));

    // 6: reset pulse mid-fill
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    tick(4);
    chk("t6_count_pre", 64'(bus.count), 64'd3);
    reset = 1'b0;
    tick();
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_addr", 64'(bus.imem_addr), 64'd0);
    reset = 1'b1;
    tick();
    chk("t6_lat_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_valid_back", 64'(bus.out_valid), 64'd1);
    chk("t6_pc", 64'(bus.out_pc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
